multi_tone_nco: RTL and testbench
=================================

// Module: multi_tone_nco
// PURPOSE
//  Synthesisable, parametrised multi-channel differential tone source. It is the hardware
//  successor of the behavioural real-valued tone/noise generator used in benches.
//  Per channel: phase-accumulator NCO, quarter-wave sine LUT, amplitude, common-mode
//  offset, LFSR noise and a saturating P/N pair.
//  Channels are time-multiplexed onto one valid/ready sample stream. It feeds DAC/loopback paths and DSP self-test.
// PARAMETERS
//  NCHAN    2   number of tone channels (1..8); CHW = max(1,$clog2(NCHAN))
//  OUT_W    16  signed output sample width (16..24)
//  PHASE_W  24  phase accumulator / frequency control word width
//  LUT_AW   8   quarter-wave LUT address bits (2**LUT_AW entries)
// PORTS
//  clk         in   1        single clock
//  reset       in   1        synchronous, active-high
//  en          in   1        0: ignore sample_tick, freeze LFSRs
//  sample_tick in   1        1-cycle strobe at the sample rate
//  cfg_we      in   1        config write strobe
//  cfg_sel     in   2        0=fcw 1=ampl 2=offset 3=noise_ampl
//  cfg_chan    in   CHW      target channel
//  cfg_data    in   32       fcw:[PHASE_W-1:0] ampl/noise_ampl:[15:0] Q1.15 offset:[OUT_W-1:0] signed
//  out_valid   out  1        sample available
//  out_ready   in   1        downstream accept
//  out_chan    out  CHW      channel of current sample
//  out_p       out  OUT_W    offset + sig + noise, signed, saturated
//  out_n       out  OUT_W    offset - sig + noise, signed, saturated
//  sat_flag    out  1        sticky: any saturation since reset
//  overrun     out  1        sticky: sample_tick arrived while not IDLE
// BEHAVIOUR
//  - Reset: every output = 0; FSM=IDLE; phases=0; fcw/ampl/offset/noise_ampl=0; channel c LFSR = 16'hACE1^c.
//    Reset mid-sample drops that sample immediately (out_valid=0 next cycle).
//  - FSM IDLE -> CALC1 -> CALC2 -> CALC3 -> OUT.
//    IDLE to CALC1 on sample_tick && en, with chan=0. CALC stages take 1 cycle each.
//    OUT holds until out_valid&&out_ready. Then chan<NCHAN-1 goes to CALC1 with chan+1, else IDLE.
//  - Latency: tick at cycle 0 -> out_valid at cycle 4. Handshake at k -> next channel valid at k+4.
//  - A tick outside IDLE is dropped and sets overrun. A tick with en=0 is ignored with no flag.
//  - CALC1 snapshots the channel's phase, ampl, offset, noise_ampl and LFSR value.
//    Config writes during a computation affect the next one.
//  - On OUT handshake: phase[c] <= phase[c] + fcw[c], mod 2**PHASE_W, wraps silently.
//  - Sine: q = phase[PHASE_W-1 -: 2], idx = phase[PHASE_W-3 -: LUT_AW].
//    Use ~idx when q[0]; negate when q[1].
//    LUT[i] = round((2**(OUT_W-1)-1)*sin(pi/2*(i+0.5)/2**LUT_AW)), filled at elaboration. No zero entry.
//  - sig = (S * ampl) >>> 15, ampl unsigned Q1.15 with 0x8000 = 1.0. Arithmetic right shift, truncating.
//  - Noise: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1 per channel, shifts every clk while en.
//    noise = (($signed(lfsr) <<< (OUT_W-16)) * noise_ampl) >>> 15.
//  - Sums are formed at OUT_W+2 bits, then clamped to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
//    Clamping either output sets sat_flag.
//  - out_p, out_n and out_chan are registered and stable while out_valid && !out_ready.
//  - cfg_chan >= NCHAN: write ignored.
// TESTING
//  1 reset held 5 cycles with ticks -> out_valid=0, out_p=out_n=0, flags 0; LFSR ch0 = 16'hACE1.
//  2 Defaults; ch0 fcw=0x400000, ampl=0x8000, offset=0, noise=0; 4 ticks ->
//    ch0 out_p = 101, 32767, -101, -32767 and out_n the negation. ch1 = 101 on every tick (fcw 0).
//  3 ch0 offset=0x7000, ampl=0x8000, fcw=0x400000; 2nd tick sample -> out_p=32767, sat_flag=1;
//    out_n = 0x7000-32767 = -4095, unsaturated.
//  4 Hold out_ready=0 for 10 cycles in OUT, pulse sample_tick -> out_p/out_n/out_chan stable, overrun=1,
//    exactly NCHAN samples for the original tick.
//  5 ampl=0, noise_ampl=0x4000, offset=0 -> out_p==out_n each sample, values vary, |out| <= 16384;
//    en=0 -> no samples.
//  6 Assert reset while out_valid=1 -> out_valid=0 next cycle; after release a tick gives ch0 phase 0 (101).

Source files
------------

// File: rtl/multi_tone_nco.sv
// Multi-channel differential tone source: per-channel NCO, quarter-wave sine LUT,
// amplitude, offset and LFSR noise, time-multiplexed onto one valid/ready sample stream.
module multi_tone_nco #(
    parameter int NCHAN    = 2,
    parameter int OUT_W    = 16,
    parameter int PHASE_W  = 24,
    parameter int LUT_AW   = 8,
    localparam int CHW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [CHW-1:0]          cfg_chan,
    input  logic [31:0]             cfg_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHW-1:0]          out_chan,
    output logic signed [OUT_W-1:0] out_p,
    output logic signed [OUT_W-1:0] out_n,
    output logic                    sat_flag,
    output logic                    overrun
);

    localparam int SW     = OUT_W + 2;
    localparam int PW     = OUT_W + 17;
    localparam int LUT_N  = 2 ** LUT_AW;
    localparam int SNAP_W = LUT_AW + 2;
    localparam logic [CHW-1:0]       LAST_CHAN = CHW'(NCHAN - 1);
    localparam logic [CHW:0]         NCHAN_W   = (CHW + 1)'(NCHAN);
    localparam logic signed [SW-1:0] SAT_HI    = SW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO    = SW'(-(2 ** (OUT_W - 1)));

    typedef enum logic [2:0] {IDLE, CALC1, CALC2, CALC3, OUT} state_t;

    // Integer Taylor series in Q30 so the table is built without real arithmetic.
    function automatic longint sine_entry(input int i);
        longint x, x2, term, acc;
        x    = (64'sd1686629713 * longint'(2 * i + 1)) >>> (LUT_AW + 1);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 9; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return (acc * longint'((2 ** (OUT_W - 1)) - 1) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic signed [OUT_W-1:0] lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        assign lut[g] = OUT_W'(sine_entry(g));
    end

    state_t state, state_nx;
    logic [CHW-1:0]          chan;
    logic [PHASE_W-1:0]      phase  [NCHAN];
    logic [PHASE_W-1:0]      fcw    [NCHAN];
    logic [15:0]             ampl   [NCHAN];
    logic [15:0]             namp   [NCHAN];
    logic signed [OUT_W-1:0] offset [NCHAN];
    logic [15:0]             lfsr   [NCHAN];

    logic [SNAP_W-1:0]       phase_s;
    logic [15:0]             ampl_s, namp_s, lfsr_s;
    logic signed [OUT_W-1:0] offset_s, sine_r;
    logic signed [SW-1:0]    noise_r;

    logic [1:0]              quad;
    logic [LUT_AW-1:0]       idx, lut_addr;
    logic signed [OUT_W-1:0] mag, sine_val, lfsr_ext, clamp_p, clamp_n;
    logic signed [PW-1:0]    nprod, sprod;
    logic signed [SW-1:0]    noise_val, sig, off_x, sum_p, sum_n;
    logic                    hi_p, lo_p, hi_n, lo_n;
    logic                    handshake, cfg_hit;
    logic                    unused_bits;

    assign out_valid   = (state == OUT);
    assign handshake   = (state == OUT) && out_ready;
    assign cfg_hit     = cfg_we && ({1'b0, cfg_chan} < NCHAN_W);
    assign unused_bits = ^{sprod[14:0], nprod[14:0], cfg_data};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_tick && en) state_nx = CALC1;
            CALC1:   state_nx = CALC2;
            CALC2:   state_nx = CALC3;
            CALC3:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = (chan == LAST_CHAN) ? IDLE : CALC1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                fcw[c]    <= '0;
                ampl[c]   <= '0;
                namp[c]   <= '0;
                offset[c] <= '0;
            end
        end else if (cfg_hit) begin
            case (cfg_sel)
                2'd0:    fcw[cfg_chan]    <= cfg_data[PHASE_W-1:0];
                2'd1:    ampl[cfg_chan]   <= cfg_data[15:0];
                2'd2:    offset[cfg_chan] <= $signed(cfg_data[OUT_W-1:0]);
                default: namp[cfg_chan]   <= cfg_data[15:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCHAN; c++) phase[c] <= '0;
        end else if (handshake) begin
            phase[chan] <= phase[chan] + fcw[chan];
        end
    end

    // Fibonacci taps 16,14,13,11 map to bits 0,2,3,5 of a right-shifting register.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (reset)   lfsr[c] <= 16'hACE1 ^ 16'(c);
            else if (en) lfsr[c] <= {lfsr[c][0] ^ lfsr[c][2] ^ lfsr[c][3] ^ lfsr[c][5], lfsr[c][15:1]};
        end
    end

    always_comb begin
        quad      = phase_s[SNAP_W-1 -: 2];
        idx       = phase_s[LUT_AW-1:0];
        lut_addr  = quad[0] ? ~idx : idx;
        mag       = lut[lut_addr];
        sine_val  = quad[1] ? -mag : mag;
        lfsr_ext  = OUT_W'($signed(lfsr_s)) <<< (OUT_W - 16);
        nprod     = PW'(lfsr_ext) * PW'($signed({1'b0, namp_s}));
        noise_val = $signed(nprod[PW-1:15]);
        sprod     = PW'(sine_r) * PW'($signed({1'b0, ampl_s}));
        sig       = $signed(sprod[PW-1:15]);
        off_x     = SW'(offset_s);
        sum_p     = off_x + sig + noise_r;
        sum_n     = off_x - sig + noise_r;
        hi_p      = sum_p > SAT_HI;
        lo_p      = sum_p < SAT_LO;
        hi_n      = sum_n > SAT_HI;
        lo_n      = sum_n < SAT_LO;
        clamp_p   = hi_p ? SAT_HI[OUT_W-1:0] : (lo_p ? SAT_LO[OUT_W-1:0] : sum_p[OUT_W-1:0]);
        clamp_n   = hi_n ? SAT_HI[OUT_W-1:0] : (lo_n ? SAT_LO[OUT_W-1:0] : sum_n[OUT_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan     <= '0;
            out_chan <= '0;
            out_p    <= '0;
            out_n    <= '0;
            sat_flag <= 1'b0;
            overrun  <= 1'b0;
            phase_s  <= '0;
            ampl_s   <= '0;
            namp_s   <= '0;
            lfsr_s   <= '0;
            offset_s <= '0;
            sine_r   <= '0;
            noise_r  <= '0;
        end else begin
            if (sample_tick && en && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_tick && en) chan <= '0;
                CALC1: begin
                    phase_s  <= phase[chan][PHASE_W-1 -: SNAP_W];
                    ampl_s   <= ampl[chan];
                    namp_s   <= namp[chan];
                    offset_s <= offset[chan];
                    lfsr_s   <= lfsr[chan];
                end
                CALC2: begin
                    sine_r  <= sine_val;
                    noise_r <= noise_val;
                end
                CALC3: begin
                    out_p    <= clamp_p;
                    out_n    <= clamp_n;
                    out_chan <= chan;
                    if (hi_p || lo_p || hi_n || lo_n) sat_flag <= 1'b1;
                end
                OUT: if (out_ready && (chan != LAST_CHAN)) chan <= chan + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_tone_nco.sv
// Scoreboard bench for multi_tone_nco: directed ticks push expected samples,
// a negedge monitor compares every presented sample against the queue head.
module tb_multi_tone_nco;

    localparam int NCHAN   = 2;
    localparam int OUT_W   = 16;
    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 8;
    localparam int CHW     = 1;

    logic                    clk = 1'b0;
    logic                    reset, en, sample_tick, cfg_we, out_ready;
    logic [1:0]              cfg_sel;
    logic [CHW-1:0]          cfg_chan;
    logic [31:0]             cfg_data;
    logic                    out_valid, sat_flag, overrun;
    logic [CHW-1:0]          out_chan;
    logic signed [OUT_W-1:0] out_p, out_n;

    multi_tone_nco #(
        .NCHAN(NCHAN), .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_chan(cfg_chan), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_p(out_p), .out_n(out_n), .sat_flag(sat_flag), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int p;
        int n;
        bit prop;
    } exp_t;

    exp_t expq[$];
    int   errors  = 0;
    int   checks  = 0;
    int   samples = 0;
    int   prev_p [NCHAN];
    bit   have_prev [NCHAN];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares on every presented cycle (stall stability included), pops on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got chan %0d p %0d with no sample expected", out_chan, out_p);
            end else begin
                e = expq[0];
                check("out_chan", out_chan, e.ch);
                if (!e.prop) begin
                    check("out_p", out_p, e.p);
                    check("out_n", out_n, e.n);
                end else begin
                    check("noise_pn_equal", out_p, out_n);
                    check("noise_bound", (out_p <= 16384 && out_p >= -16384) ? 1 : 0, 1);
                    if (out_ready && have_prev[out_chan])
                        check("noise_varies", (int'(out_p) != prev_p[out_chan]) ? 1 : 0, 1);
                end
                if (out_ready) begin
                    void'(expq.pop_front());
                    prev_p[out_chan]    = out_p;
                    have_prev[out_chan] = 1'b1;
                    samples++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        expq.delete();
        for (int c = 0; c < NCHAN; c++) have_prev[c] = 1'b0;
        reset = 1'b0;
    endtask

    task automatic cfg(input int sel, input int ch, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_chan = CHW'(ch);
        cfg_data = 32'(data);
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic push(input int ch, input int p, input int n, input bit prop);
        expq.push_back(exp_t'{ch, p, n, prop});
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (expq.size() != 0 && c < budget) begin
            step(1);
            c++;
        end
        check("drain_remaining", expq.size(), 0);
    endtask

    int t2_p [4] = '{101, 32767, -101, -32767};
    int base;

    initial begin
        reset = 1'b1; en = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        cfg_sel = '0; cfg_chan = '0; cfg_data = '0;
        for (int c = 0; c < NCHAN; c++) begin prev_p[c] = 0; have_prev[c] = 1'b0; end

        // 1: reset held with ticks
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1;
            step(1);
        end
        sample_tick = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_n", out_n, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_overrun", overrun, 0);
        check("rst_lfsr0", dut.lfsr[0], 16'hACE1);
        reset = 1'b0;
        step(1);

        // 2: quarter-turn fcw on ch0, fcw 0 on ch1
        do_reset();
        cfg(0, 0, 32'h400000);
        cfg(1, 0, 32'h8000);
        cfg(1, 1, 32'h8000);
        for (int k = 0; k < 4; k++) begin
            push(0, t2_p[k], -t2_p[k], 1'b0);
            push(1, 101, -101, 1'b0);
            tick();
            wait_drain(40);
        end

        // 3: offset drives out_p into saturation, out_n stays in range
        do_reset();
        cfg(2, 0, 32'h7000);
        cfg(1, 0, 32'h8000);
        cfg(0, 0, 32'h400000);
        push(0, 28773, 28571, 1'b0);
        push(1, 0, 0, 1'b0);
        tick();
        wait_drain(40);
        check("sat_before", sat_flag, 0);
        push(0, 32767, -4095, 1'b0);
        push(1, 0, 0, 1'b0);
        tick();
        wait_drain(40);
        check("sat_after", sat_flag, 1);

        // 4: back-pressure in OUT plus a tick while busy
        do_reset();
        cfg(1, 0, 32'h8000);
        cfg(1, 1, 32'h8000);
        base = samples;
        push(0, 101, -101, 1'b0);
        push(1, 101, -101, 1'b0);
        out_ready = 1'b0;
        tick();
        step(3);
        check("stall_valid", out_valid, 1);
        step(5);
        tick();
        step(4);
        check("stall_valid_end", out_valid, 1);
        out_ready = 1'b1;
        wait_drain(40);
        step(20);
        check("overrun", overrun, 1);
        check("stall_sample_count", samples - base, NCHAN);

        // 5: noise only; exact first snapshot, then free-running, then en=0
        en = 1'b0;
        do_reset();
        cfg(3, 0, 32'h4000);
        cfg(3, 1, 32'h4000);
        push(0, 11064, 11064, 1'b0);
        push(1, -5320, -5320, 1'b0);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_drain(40);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 0, 1'b1);
            push(1, 0, 0, 1'b1);
            tick();
            step(k);
            wait_drain(40);
        end
        en = 1'b0;
        base = samples;
        for (int k = 0; k < 3; k++) begin
            tick();
            step(2);
        end
        step(20);
        check("en0_no_samples", samples - base, 0);
        check("en0_no_overrun", overrun, 0);
        en = 1'b1;

        // 6: reset while a sample is presented
        do_reset();
        cfg(1, 0, 32'h8000);
        cfg(0, 0, 32'h400000);
        push(0, 101, -101, 1'b0);
        push(1, 0, 0, 1'b0);
        tick();
        step(3);
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        expq.delete();
        step(1);
        check("reset_drop_valid", out_valid, 0);
        reset = 1'b0;
        cfg(1, 0, 32'h8000);
        cfg(0, 0, 32'h400000);
        push(0, 101, -101, 1'b0);
        push(1, 0, 0, 1'b0);
        tick();
        wait_drain(40);
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
